// File: rtl/mult_result_buffer.sv
// Result buffer behind the FP multiplier sequencer: edge-detected capture into a
// first-word-fall-through FIFO, batch tracking, and a sticky overflow flag.
`timescale 1ns/1ps
module mult_result_buffer #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 8,
   parameter int ADDR_W      = 3,
   parameter int NUM_RESULTS = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              mult_done,
   input  logic [DATA_W-1:0] mult_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W:0]   fifo_count,
   output logic              batch_done,
   output logic              overflow
);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   L_DEPTH   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   L_NUM     = (ADDR_W+1)'(NUM_RESULTS);
   localparam logic [ADDR_W:0]   L_CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   L_CNT_ZERO = (ADDR_W+1)'(0);
   localparam logic [ADDR_W-1:0] L_PTR_ONE = ADDR_W'(1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W-1:0]   r_rd_ptr;
   logic [ADDR_W:0]     r_count;
   logic [ADDR_W:0]     r_captured;
   logic                r_done_d1;
   logic                r_valid;
   logic [DATA_W-1:0]   r_data;
   logic                r_batch_done;
   logic                r_overflow;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_cap;
   logic                w_full;
   logic                w_rd;
   logic                w_wr;
   logic                w_drop;
   logic [ADDR_W:0]     w_count_nxt;
   logic [ADDR_W:0]     w_captured_nxt;
   logic [ADDR_W-1:0]   w_rd_ptr_nxt;
   logic [ADDR_W-1:0]   w_wr_ptr_nxt;
   logic [DATA_W-1:0]   w_head_nxt;

   // Capture/read qualification, next occupancy, next head word and batch FSM.
   always_comb begin
      w_cap          = mult_done & ~r_done_d1;
      w_full         = (r_count == L_DEPTH);
      w_rd           = r_valid & out_ready;
      w_wr           = w_cap & (r_state == ST_COLLECT) & (~w_full | w_rd);
      w_drop         = w_cap & ~w_wr;
      w_count_nxt    = r_count;
      w_captured_nxt = r_captured;
      w_rd_ptr_nxt   = r_rd_ptr;
      w_wr_ptr_nxt   = r_wr_ptr;
      w_state_nxt    = r_state;

      case ({w_wr, w_rd})
         2'b10:   w_count_nxt = r_count + L_CNT_ONE;
         2'b01:   w_count_nxt = r_count - L_CNT_ONE;
         default: w_count_nxt = r_count;
      endcase

      if (w_rd) begin
         w_rd_ptr_nxt = r_rd_ptr + L_PTR_ONE;
      end else begin
         w_rd_ptr_nxt = r_rd_ptr;
      end

      if (w_wr) begin
         w_wr_ptr_nxt   = r_wr_ptr + L_PTR_ONE;
         w_captured_nxt = r_captured + L_CNT_ONE;
      end else begin
         w_wr_ptr_nxt   = r_wr_ptr;
         w_captured_nxt = r_captured;
      end

      // A word written this cycle into the slot that becomes head must bypass the array.
      if (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) begin
         w_head_nxt = mult_result;
      end else begin
         w_head_nxt = r_mem[w_rd_ptr_nxt];
      end

      case (r_state)
         ST_COLLECT: begin
            if (w_wr && (w_captured_nxt == L_NUM)) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_state_nxt = ST_COLLECT;
            end
         end
         ST_DRAIN: begin
            if (r_count == L_CNT_ZERO) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DONE:  w_state_nxt = ST_DONE;
         default:  w_state_nxt = ST_COLLECT;
      endcase
   end

   // Storage array; contents need no reset.
   always_ff @(posedge clk) begin
      if (w_wr && !clear) begin
         r_mem[r_wr_ptr] <= mult_result;
      end
   end

   // Control state, pointers, registered outputs; clear outranks capture and read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_COLLECT;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_captured   <= '0;
         r_done_d1    <= 1'b0;
         r_valid      <= 1'b0;
         r_data       <= '0;
         r_batch_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_done_d1 <= mult_done;
         if (clear) begin
            r_state      <= ST_COLLECT;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_captured   <= '0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_batch_done <= 1'b0;
            r_overflow   <= 1'b0;
         end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            r_captured   <= w_captured_nxt;
            r_valid      <= (w_count_nxt != L_CNT_ZERO);
            r_data       <= w_head_nxt;
            r_batch_done <= (w_state_nxt == ST_DONE);
            r_overflow   <= r_overflow | w_drop;
         end
      end
   end

   assign out_valid  = r_valid;
   assign out_data   = r_data;
   assign fifo_count = r_count;
   assign batch_done = r_batch_done;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_mult_result_buffer.sv
// Self-checking bench: two instances (NUM_RESULTS 5 and 12) selected by sel,
// compared every cycle against a queue-based batch model.
`timescale 1ns/1ps
module tb_mult_result_buffer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        clear = 1'b0;
   logic        done = 1'b0;
   logic        ready = 1'b0;
   logic        sel = 1'b0;
   logic [31:0] result = 32'd0;

   logic        va, vb, bda, bdb, ova, ovb;
   logic [31:0] da, db;
   logic [3:0]  ca, cb;
   logic        ov, obd, oovf;
   logic [31:0] od;
   logic [3:0]  oc;

   int checks = 0;
   int failures = 0;

   logic [31:0] q[$];
   int          m_cnt = 0;
   int          m_phase = 0;
   int          n_res = 5;
   bit          m_bdone = 1'b0;
   bit          m_ovf = 1'b0;
   bit          m_prev = 1'b0;
   logic [31:0] saved [9];

   always #5 clk = ~clk;

   mult_result_buffer #(.DATA_W(32), .DEPTH(8), .ADDR_W(3), .NUM_RESULTS(5)) u_dut5 (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .mult_done(done & ~sel), .mult_result(result),
      .out_valid(va), .out_ready(ready & ~sel), .out_data(da),
      .fifo_count(ca), .batch_done(bda), .overflow(ova));

   mult_result_buffer #(.DATA_W(32), .DEPTH(8), .ADDR_W(3), .NUM_RESULTS(12)) u_dut12 (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .mult_done(done & sel), .mult_result(result),
      .out_valid(vb), .out_ready(ready & sel), .out_data(db),
      .fifo_count(cb), .batch_done(bdb), .overflow(ovb));

   assign ov   = sel ? vb  : va;
   assign od   = sel ? db  : da;
   assign oc   = sel ? cb  : ca;
   assign obd  = sel ? bdb : bda;
   assign oovf = sel ? ovb : ova;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_cnt = 0; m_phase = 0; m_bdone = 1'b0; m_ovf = 1'b0; m_prev = 1'b0;
   endtask

   // Advances the batch model by one clock using the inputs currently applied.
   task automatic model_step();
      bit cap, rd, wr;
      cap = done && !m_prev;
      if (clear) begin
         q.delete();
         m_cnt = 0; m_phase = 0; m_bdone = 1'b0; m_ovf = 1'b0;
      end else begin
         rd = (q.size() != 0) && ready;
         wr = cap && (m_phase == 0) && ((q.size() < 8) || rd);
         if (cap && !wr) m_ovf = 1'b1;
         if (m_phase == 1 && q.size() == 0) begin
            m_phase = 2; m_bdone = 1'b1;
         end
         if (rd) void'(q.pop_front());
         if (wr) begin
            q.push_back(result);
            m_cnt++;
            if (m_cnt == n_res) m_phase = 1;
         end
      end
      m_prev = done;
   endtask

   task automatic check_all();
      chk("valid", {31'd0, ov}, {31'd0, (q.size() != 0)});
      chk("count", {28'd0, oc}, q.size());
      chk("batch_done", {31'd0, obd}, {31'd0, m_bdone});
      chk("overflow", {31'd0, oovf}, {31'd0, m_ovf});
      if (q.size() != 0) chk("data", od, q[0]);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic pulse(input logic [31:0] val);
      done = 1'b1; result = val;
      tick();
      done = 1'b0;
      tick();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic wait_bdone(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (obd) break;
         tick();
      end
      chk(tag, {31'd0, obd}, 32'd1);
   endtask

   initial begin
      logic [31:0] t1 [5];
      logic [31:0] nv;
      t1[0] = 32'h3F800000; t1[1] = 32'h40000000; t1[2] = 32'h40400000;
      t1[3] = 32'h40800000; t1[4] = 32'h40A00000;

      // Reset state
      #2;
      model_reset();
      check_all();
      chk("rst_data", od, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // 1: capture order, one-cycle latency, batch completion
      ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         done = 1'b1; result = t1[i];
         tick();
         chk("t1_valid", {31'd0, ov}, 32'd1);
         chk("t1_data", od, t1[i]);
         done = 1'b0;
         tick();
      end
      wait_bdone("t1_bdone");
      chk("t1_ovf", {31'd0, oovf}, 32'd0);

      // 5: capture after batch done, then clear
      pulse($urandom);
      chk("t5_ovf", {31'd0, oovf}, 32'd1);
      chk("t5_count", {28'd0, oc}, 32'd0);
      chk("t5_bdone", {31'd0, obd}, 32'd1);
      pulse_clear();
      tick();
      chk("t5_clr_bdone", {31'd0, obd}, 32'd0);
      chk("t5_clr_ovf", {31'd0, oovf}, 32'd0);

      // 2: held level gives one entry
      ready = 1'b0;
      done = 1'b1; result = 32'h41200000;
      for (int i = 0; i < 10; i++) tick();
      done = 1'b0;
      tick();
      chk("t2_count", {28'd0, oc}, 32'd1);
      chk("t2_data", od, 32'h41200000);
      pulse_clear();
      tick();

      // 6: reset mid-batch, then a fresh batch
      for (int i = 0; i < 3; i++) pulse($urandom);
      reset_n = 1'b0;
      #2;
      model_reset();
      check_all();
      chk("t6_valid", {31'd0, ov}, 32'd0);
      chk("t6_count", {28'd0, oc}, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check_all();
      ready = 1'b1;
      for (int i = 0; i < 5; i++) pulse($urandom);
      wait_bdone("t6_bdone");
      chk("t6_ovf", {31'd0, oovf}, 32'd0);

      // Switch to the NUM_RESULTS=12 instance
      ready = 1'b0;
      sel = 1'b1;
      n_res = 12;
      pulse_clear();
      tick();

      // 3: full and drop
      for (int i = 0; i < 9; i++) begin
         saved[i] = $urandom;
         pulse(saved[i]);
      end
      chk("t3_count", {28'd0, oc}, 32'd8);
      chk("t3_ovf", {31'd0, oovf}, 32'd1);
      ready = 1'b1;
      chk("t3_head0", od, saved[0]);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("t3_drain", od, saved[i]);
      end
      tick();
      chk("t3_empty", {31'd0, ov}, 32'd0);
      ready = 1'b0;
      pulse_clear();
      tick();

      // 4: full with simultaneous read
      for (int i = 0; i < 8; i++) begin
         saved[i] = $urandom;
         pulse(saved[i]);
      end
      chk("t4_full", {28'd0, oc}, 32'd8);
      nv = $urandom;
      done = 1'b1; result = nv; ready = 1'b1;
      tick();
      done = 1'b0;
      chk("t4_count", {28'd0, oc}, 32'd8);
      chk("t4_ovf", {31'd0, oovf}, 32'd0);
      chk("t4_head", od, saved[1]);
      for (int i = 0; i < 7; i++) tick();
      chk("t4_tail", od, nv);
      chk("t4_last", {28'd0, oc}, 32'd1);
      ready = 1'b0;
      pulse_clear();
      tick();

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         done   = ($urandom_range(0, 2) == 0);
         ready  = ($urandom_range(0, 3) != 0);
         result = $urandom;
         clear  = ($urandom_range(0, 79) == 0);
         tick();
      end
      clear = 1'b0;
      done = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_result_buffer.md
Name: mult_result_buffer

Overview:
- Downstream stage of the FP multiplier sequencer.
- Captures one product per multiply-done event into a small FIFO and presents results to the consumer on a valid/ready interface.
- Tracks batch progress and flags a completed batch once NUM_RESULTS products are captured and drained.
- Flags dropped or unexpected captures.

Parameters:
DATA_W, 32, width of a multiplier product (IEEE-754 single).
DEPTH, 8, FIFO entries; power of two, at least 2.
ADDR_W, 3, log2(DEPTH).
NUM_RESULTS, 5, products expected per batch; range 1 to 2^(ADDR_W+1)-1.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous batch restart; one-cycle pulse.
mult_done  input  1  multiplier done level; may stay high for several cycles.
mult_result  input  DATA_W  product; stable while mult_done is high.
out_valid  output  1  head entry available.
out_ready  input  1  consumer accepts the head entry.
out_data  output  DATA_W  head entry (first-word-fall-through).
fifo_count  output  ADDR_W+1  occupancy, 0..DEPTH.
batch_done  output  1  batch captured and drained.
overflow  output  1  sticky error flag.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Pointers and count to 0, state to COLLECT, captured count to 0.
  - mult_done delay register to 0.
  - out_valid=0, out_data=0, fifo_count=0, batch_done=0, overflow=0.
  - Storage contents are don't-care.
- Capture event:
  - cap = mult_done & ~mult_done_d1, where mult_done_d1 is a registered copy of mult_done.
  - Exactly one event per rising edge, regardless of how long mult_done stays high.
  - mult_result is sampled in the cycle cap is high.
- Write:
  - wr = cap & state==COLLECT & (not full, or rd in the same cycle).
  - Data goes to mem[wr_ptr]; wr_ptr increments mod DEPTH; captured count increments.
- Read:
  - rd = out_valid & out_ready; rd_ptr increments mod DEPTH.
  - out_valid = (fifo_count != 0).
  - out_data = mem[rd_ptr], registered: the value updates the cycle after any pointer or count change, so it is aligned with out_valid.
- Count rules:
  - wr only: count +1.
  - rd only: count -1.
  - wr and rd together: count unchanged.
- Latency: a product captured at cycle N makes out_valid high at N+1 if the FIFO was empty. There is no same-cycle bypass.
- Full, no read: the capture is dropped, overflow is set, and the captured count is unchanged.
- Full with rd in the same cycle: the capture is accepted.
- Empty: out_ready is ignored and nothing changes.
- Wrap-around: both pointers wrap naturally from DEPTH-1 to 0. fifo_count distinguishes full from empty.
- State machine:
  - COLLECT: when the captured count reaches NUM_RESULTS on a wr, go to DRAIN.
  - DRAIN: captures are ignored and set overflow. Reads continue. When fifo_count==0, go to DONE.
  - DONE: batch_done=1 (registered, asserted the cycle DONE is entered). Captures are ignored and set overflow. DONE holds until clear.
- clear:
  - Resets pointers, count, captured count, state to COLLECT, batch_done=0, overflow=0, out_valid=0.
  - Has priority over a capture or read in the same cycle; both are discarded.
  - Does not reset mult_done_d1, so a mult_done held high across clear does not re-trigger.
- Reset asserted mid-operation discards all contents immediately. No output glitches beyond the asynchronous clear.
- overflow is sticky; only reset_n or clear clears it.

Test Plan:
1. Capture order: five mult_done pulses with results 0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000; out_ready=1 throughout -> out_data is those five values in order, each valid one cycle after capture; batch_done=1 after the fifth is drained; overflow=0.
2. Held level: mult_done held high for 10 cycles with result 0x41200000 -> exactly one entry, fifo_count=1.
3. Full and drop: NUM_RESULTS=12, out_ready=0, nine captures -> fifo_count=8 and overflow=1 after the ninth; draining yields the first eight values only.
4. Full with simultaneous read: fill to 8, then a capture and a read in the same cycle -> fifo_count stays 8, overflow=0, and the new value appears at the tail after seven more reads.
5. Post-batch capture: after batch_done=1, another mult_done pulse -> overflow=1, fifo_count=0, batch_done stays 1; a clear pulse -> batch_done=0, overflow=0, state COLLECT.
6. Reset mid-batch: three captures, then reset_n low for one cycle -> out_valid=0, fifo_count=0, batch_done=0; five new captures complete a fresh batch normally.
